ram_port_arbiter: RTL and testbench

//  Shares the single-port 256-byte BRAM between the CPU and a debug/monitor requester (the LCD inspector or a program loader).

---
 rtl/ram_port_arbiter_pkg.sv | 21 ++
 rtl/ram_port_arbiter_if.sv | 40 ++++
 rtl/ram_port_arbiter_grant_logic.sv | 39 +++
 rtl/ram_port_arbiter.sv | 101 ++++++++++
 tb/tb_ram_port_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the CPU/debug BRAM port arbiter.
// Build option: define RAM_ARB_DBG_WRITE_EN to let the debug master write.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DATA  = 2'b10
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int unsigned CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters, the BRAM port and the arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              en;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  en, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output en, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/ram_port_arbiter_grant_logic.sv
// Winner selection with CPU priority and a starvation counter that
// forces a debug grant after STARVE_LIMIT contended CPU grants.
module ram_arb_grant_logic
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arb,
  input  logic             en,
  input  logic             cpu_req,
  input  logic             dbg_req,
  output logic             grant,
  output logic             winner,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  always_comb begin
    grant  = arb && en && (cpu_req || dbg_req);
    winner = OWN_CPU;
    if (dbg_req && (!cpu_req || starve_cnt == LIMIT))
      winner = OWN_DBG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (arb) begin
      if (!dbg_req || (grant && winner == OWN_DBG))
        starve_cnt <= '0;
      else if (grant)
        starve_cnt <= sat_inc(starve_cnt, LIMIT);
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port BRAM arbiter: IDLE -> ISSUE -> DATA, one access per 3 cycles.
// Build option RAM_ARB_DBG_WRITE_EN enables debug writes; otherwise debug is read-only.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_qzt,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus
);

  state_t           state;
  logic             acc_we;
  logic             grant;
  logic             winner;
  logic             dbg_write;
  logic [CNT_W-1:0] starve_cnt;

`ifdef RAM_ARB_DBG_WRITE_EN
  assign dbg_write = bus.dbg_we;
`else
  assign dbg_write = 1'b0;
`endif

  ram_arb_grant_logic #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk_qzt),
    .reset     (reset),
    .arb       (state == ST_IDLE),
    .en        (bus.en),
    .cpu_req   (bus.cpu_req),
    .dbg_req   (bus.dbg_req),
    .grant     (grant),
    .winner    (winner),
    .starve_cnt(starve_cnt)
  );

  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state         <= ST_IDLE;
      acc_we        <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= OWN_CPU;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cpu_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
          if (grant) begin
            bus.owner  <= winner;
            bus.mem_en <= 1'b1;
            bus.busy   <= 1'b1;
            state      <= ST_ISSUE;
            if (winner == OWN_CPU) begin
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
              acc_we        <= bus.cpu_we;
            end else begin
              bus.mem_we    <= dbg_write;
              bus.mem_addr  <= bus.dbg_addr;
              bus.mem_wdata <= bus.dbg_wdata;
              acc_we        <= dbg_write;
            end
          end
        end
        ST_ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= ST_DATA;
        end
        ST_DATA: begin
          // Read data from the BRAM is valid here, one cycle after it sampled.
          if (bus.owner == OWN_CPU) begin
            bus.cpu_ack <= 1'b1;
            if (!acc_we) bus.cpu_rdata <= bus.mem_rdata;
          end else begin
            bus.dbg_ack <= 1'b1;
            if (!acc_we) bus.dbg_rdata <= bus.mem_rdata;
          end
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural 256-byte BRAM.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_port_arbiter #(
    .ADDR_W(8),
    .DATA_W(8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_qzt(clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  // BRAM contents are reloaded to a known pattern whenever reset is high.
  logic [7:0] bram [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) bram[i] <= 8'(i) ^ 8'h5A;
      bram[8'h10] <= 8'hA5;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bram[bus.mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       dbg;
    logic [7:0] rdata;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       dbg;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_mem_we;
  } vec_t;
  vec_t vecs[9];

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.cpu_ack) begin
        if (sbq.size() == 0) check("unexpected_cpu_ack", bus.cpu_ack, 0);
        else begin
          e = sbq.pop_front();
          check("cpu_ack_owner", bus.owner, e.dbg);
          check("cpu_rdata", bus.cpu_rdata, e.rdata);
        end
      end
      if (bus.dbg_ack) begin
        if (sbq.size() == 0) check("unexpected_dbg_ack", bus.dbg_ack, 0);
        else begin
          e = sbq.pop_front();
          check("dbg_ack_owner", bus.owner, e.dbg);
          check("dbg_rdata", bus.dbg_rdata, e.rdata);
        end
      end
    end
  end

  task automatic access(input vec_t v, input int idx);
    int lat = 0, en_cnt = 0, we_cnt = 0;
    bit got = 0;
    @(negedge clk);
    if (v.dbg) begin
      bus.dbg_req = 1; bus.dbg_we = v.we; bus.dbg_addr = v.addr; bus.dbg_wdata = v.wdata;
    end else begin
      bus.cpu_req = 1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    end
    sbq.push_back('{v.dbg, v.exp_rdata});
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      en_cnt += int'(bus.mem_en);
      we_cnt += int'(bus.mem_we);
      if (lat == 1) begin
        check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
        // Payload moves after acceptance must not reach the BRAM.
        bus.cpu_addr = ~v.addr; bus.dbg_addr = ~v.addr;
        bus.cpu_wdata = ~v.wdata; bus.dbg_wdata = ~v.wdata;
      end
      if (v.dbg ? bus.dbg_ack : bus.cpu_ack) got = 1;
    end
    bus.cpu_req = 0;
    bus.dbg_req = 0;
    check($sformatf("v%0d_ack_seen", idx), 64'(got), 1);
    check($sformatf("v%0d_latency", idx), lat, 3);
    check($sformatf("v%0d_mem_en_cycles", idx), en_cnt, 1);
    check($sformatf("v%0d_mem_we_cycles", idx), we_cnt, 64'(v.exp_mem_we));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, prev, n, en_cnt;
    bit got;

    reset = 1;
    bus.en = 1; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack,
                            bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata, bus.busy, bus.owner}, 0);
    reset = 0;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'hA5, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h11, 8'h3C, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0};
`ifdef RAM_ARB_DBG_WRITE_EN
    vecs[6] = '{1'b1, 1'b1, 8'h20, 8'h77, 8'h11, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0};
`else
    vecs[6] = '{1'b1, 1'b1, 8'h20, 8'h77, 8'h7A, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h7A, 1'b0};
`endif
    vecs[8] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0};
    foreach (vecs[i]) access(vecs[i], i);
    @(negedge clk);
    check("sb_drained_table", sbq.size(), 0);

    // Reset while the access sits in ISSUE: abandoned with no ack.
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h99;
    @(negedge clk);
    check("rst_issue_mem_en", bus.mem_en, 1);
    reset = 1; bus.cpu_req = 0;
    @(negedge clk);
    check("rst_issue_outputs", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack,
                                bus.dbg_ack, bus.cpu_rdata, bus.dbg_rdata, bus.busy, bus.owner}, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    check("rst_issue_idle_busy", bus.busy, 0);
    access('{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0}, 100);

    // en dropped during ISSUE: access finishes, next request waits for en.
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    sbq.push_back('{1'b0, 8'hA5});
    @(negedge clk);
    bus.en = 0;
    got = 0; cyc = 1;
    while (!got && cyc < 10) begin
      @(negedge clk); cyc++;
      if (bus.cpu_ack) got = 1;
    end
    bus.cpu_req = 0;
    check("en_drop_ack_latency", cyc, 3);
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 8'h10;
    en_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      en_cnt += int'(bus.mem_en) + int'(bus.busy);
    end
    check("en_low_no_grant", en_cnt, 0);
    sbq.push_back('{1'b1, 8'hA5});
    bus.en = 1;
    got = 0; cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk); cyc++;
      if (bus.dbg_ack) got = 1;
    end
    bus.dbg_req = 0;
    check("en_restore_latency", cyc, 3);

    // Contention with STARVE_LIMIT=4: CPU x4, DBG, and the pattern repeats.
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h01;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 8'h02;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) sbq.push_back('{1'b1, 8'h58});
      else                  sbq.push_back('{1'b0, 8'h5B});
    end
    cyc = 0; prev = 0; n = 0;
    while (n < 10 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (bus.cpu_ack || bus.dbg_ack) begin
        n++;
        if (n > 1) check($sformatf("contention_gap_%0d", n), cyc - prev, 3);
        prev = cyc;
      end
    end
    bus.cpu_req = 0; bus.dbg_req = 0;
    check("contention_count", n, 10);
    repeat (4) @(negedge clk);
    check("sb_drained_final", sbq.size(), 0);
    check("final_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
